cache_datapath: RTL

Datapath for the direct-mapped write-through cache. The cache controller FSM drives this block through LdCtr, RdyEn, Rdy, W, WSel and RSel. This block returns M (tag match), V (valid) and CtrSig (memory latency elapsed) to the FSM. It holds the CPU request latch, the tag/valid/data arrays, the memory-latency counter and the CPU read-data register, and sits between the CPU port and main memory.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_lat_counter.sv | 36 +++
 rtl/cache_datapath.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache datapath.
// Geometry constants below are the default build (16-bit words, 16 lines).
package cache_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_INDEX_W = 4;
    localparam int NUM_LINES   = 2 ** DEF_INDEX_W;
    localparam int TAG_W       = DEF_ADDR_W - DEF_INDEX_W;
    localparam int CTR_W       = 8;

    // One cache line: a single data word plus its tag and valid bit.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [DEF_DATA_W-1:0] data;
    } line_t;

endpackage

// File: rtl/cache_lat_counter.sv
// Memory-latency down-counter. Loading arms it with MEM_LATENCY-1; it then
// counts down to zero and holds there. CtrSig reports "latency elapsed" and is
// suppressed in the load cycle itself so a fresh load never reads as done.
module cache_lat_counter
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic LdCtr,
    output logic CtrSig
);

    localparam logic [CTR_W-1:0] LOAD_VAL = CTR_W'(MEM_LATENCY - 1);
    localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

    logic [CTR_W-1:0] count_r;

    // Load on LdCtr, otherwise decrement and saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CTR_ZERO;
        end else if (LdCtr) begin
            count_r <= LOAD_VAL;
        end else if (count_r != CTR_ZERO) begin
            count_r <= count_r - CTR_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign CtrSig = (count_r == CTR_ZERO) && !LdCtr;

endmodule

// File: rtl/cache_datapath.sv
// Datapath of the direct-mapped write-through cache: CPU request latch,
// tag/valid/data arrays, latency counter and registered CPU read data.
// Optional build macro: CACHE_STATS_EN adds hit_cnt/miss_cnt outputs.
module cache_datapath
    import cache_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int INDEX_W     = DEF_INDEX_W,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Strobe,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              LdCtr,
    input  logic              RdyEn,
    input  logic              Rdy,
    input  logic              W,
    input  logic              WSel,
    input  logic              RSel,
    output logic              M,
    output logic              V,
    output logic              CtrSig,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int LINES    = 2 ** INDEX_W;
    localparam int TAG_BITS = ADDR_W - INDEX_W;

    logic                busy_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   din_r;
    logic                capture_s;
    logic [INDEX_W-1:0]  idx_s;
    logic [TAG_BITS-1:0] tag_s;
    logic [LINES-1:0]    valid_r;
    logic [TAG_BITS-1:0] tag_r  [LINES];
    logic [DATA_W-1:0]   data_r [LINES];
    line_t               cur_line_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic [DATA_W-1:0]   rd_data_s;

    assign capture_s = Strobe && !busy_r;
    assign idx_s     = addr_r[INDEX_W-1:0];
    assign tag_s     = addr_r[ADDR_W-1:INDEX_W];
    assign mem_addr  = addr_r;
    assign mem_wdata = din_r;

    // Request latch: capture a new request only when idle; Rdy ends the transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            addr_r <= {ADDR_W{1'b0}};
            din_r  <= {DATA_W{1'b0}};
        end else begin
            if (capture_s) begin
                addr_r <= cpu_addr;
                din_r  <= cpu_din;
            end else begin
                addr_r <= addr_r;
                din_r  <= din_r;
            end
            if (Rdy) begin
                busy_r <= 1'b0;
            end else if (capture_s) begin
                busy_r <= 1'b1;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    // Line view at the latched index plus write-source and forwarded-read muxes.
    always_comb begin
        cur_line_s.valid = valid_r[idx_s];
        cur_line_s.tag   = tag_r[idx_s];
        cur_line_s.data  = data_r[idx_s];
        if (WSel) begin
            wr_data_s = mem_rdata;
        end else begin
            wr_data_s = din_r;
        end
        // A line being written this cycle is read as its new contents.
        if (W) begin
            rd_data_s = wr_data_s;
        end else begin
            rd_data_s = cur_line_s.data;
        end
    end

    assign M = (cur_line_s.tag == tag_s);
    assign V = cur_line_s.valid;

    // Valid bits: cleared by reset so every line misses afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {LINES{1'b0}};
        end else if (W) begin
            valid_r[idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data arrays: no reset, contents are qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (W) begin
            tag_r[idx_s]  <= tag_s;
            data_r[idx_s] <= wr_data_s;
        end
    end

    // CPU read-data register: a line write takes priority over a read hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_dout <= {DATA_W{1'b0}};
        end else if (W) begin
            cpu_dout <= RSel ? din_r : mem_rdata;
        end else if (RdyEn) begin
            cpu_dout <= rd_data_s;
        end else begin
            cpu_dout <= cpu_dout;
        end
    end

    cache_lat_counter #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_lat_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .LdCtr  (LdCtr),
        .CtrSig (CtrSig)
    );

`ifdef CACHE_STATS_EN
    logic first_r;

    // Flag the first cycle after a capture, when M/V first describe the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_r <= 1'b0;
        end else begin
            first_r <= capture_s;
        end
    end

    // Count each transaction once, as a hit or a miss, wrapping at 16'hFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= 16'd0;
            miss_cnt <= 16'd0;
        end else if (first_r && M && V) begin
            hit_cnt  <= hit_cnt + 16'd1;
            miss_cnt <= miss_cnt;
        end else if (first_r) begin
            hit_cnt  <= hit_cnt;
            miss_cnt <= miss_cnt + 16'd1;
        end else begin
            hit_cnt  <= hit_cnt;
            miss_cnt <= miss_cnt;
        end
    end
`endif

endmodule
